drive_sequencer: RTL and testbench
==================================

# drive_sequencer

Frame-synchronous command sequencer for the ESC drive channel of the car. It accepts drive/stop/back commands from the remote-control decoder and runs the ESC arming hold. It enforces the brake-then-neutral sequence required to reverse out of forward motion, and forces stop on command timeout. It outputs the 2-bit drive code to the PWM generator, changing it only at 20 ms frame boundaries.

## Interface
Parameters:
- FRAME_TICKS, 40: clk_dec ticks per PWM frame (0.5 ms tick, 20 ms frame).
- ARM_FRAMES, 50: frames of forced stop after reset before commands are accepted.
- BRAKE_FRAMES, 4: frames of back output when reversing out of forward.
- NEUTRAL_FRAMES, 5: frames of stop between brake and reverse.
- TIMEOUT_FRAMES, 25: frame boundaries without an accepted command before failsafe.

Ports:
- clk_dec  in  1  tick clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd  in  2  10 = drive, 00 = stop, 01 = back, 11 = reserved (treated as stop).
- cmd_ready  out  1  equals armed.
- drive  out  2  registered drive code to the PWM generator, same encoding as cmd.
- armed  out  1  arming complete.
- failsafe  out  1  timeout active.
- frame_start  out  1  high on the last tick of each frame (fcnt == FRAME_TICKS).

## Operation
- Frame counter fcnt runs 1..FRAME_TICKS and wraps to 1. It resets to 1, so it stays aligned with the PWM generator's counter.
- A command is accepted when cmd_valid && cmd_ready. It is stored in the target register tgt, which resets to stop.
- Effective target eff:
  - If a command is accepted this cycle, eff is that command (bypass).
  - Otherwise, if failsafe = 1, eff is stop.
  - Otherwise eff is tgt.
- Watchdog:
  - An accepted command clears wd and failsafe.
  - Otherwise wd increments at each frame_start while armed and saturates.
  - failsafe sets at the frame_start where wd reaches TIMEOUT_FRAMES.
  - If a command is accepted in that same cycle, the command wins and failsafe stays 0.
- State transitions are evaluated only in frame_start cycles. phase counts frame boundaries spent in the current state and clears on every state entry.
  - ARM: after ARM_FRAMES boundaries, go to IDLE and set armed.
  - IDLE: eff = drive goes to FWD; eff = back goes to REV.
  - FWD: eff = stop goes to IDLE; eff = back goes to BRAKE.
  - BRAKE: eff = drive goes to FWD; eff = stop goes to IDLE. Otherwise, after BRAKE_FRAMES boundaries, go to NEUTRAL.
  - NEUTRAL: eff = drive goes to FWD; eff = stop goes to IDLE. After NEUTRAL_FRAMES boundaries with eff = back, go to REV.
  - REV: eff = stop goes to IDLE; eff = drive goes to FWD.
- Drive output by state:
  - ARM, IDLE, NEUTRAL give stop (00).
  - FWD gives drive (10).
  - BRAKE and REV give back (01).
- drive is registered from the next state, so a change appears on fcnt = 1 of the following frame. drive never changes mid-frame.
- Reserved code 11 is stored as stop.

## Timing
- Reset values:
  - drive = 00; armed, cmd_ready, failsafe = 0.
  - frame_start = 0; fcnt = 1; state = ARM; tgt = stop; wd = 0; phase = 0.
- Reset asserted mid-operation returns the block to ARM with drive = 00 on the next edge. The full arming hold repeats.
- Arming: the first frame_start is in cycle FRAME_TICKS−1 after reset release. armed rises in cycle ARM_FRAMES·FRAME_TICKS, which is 2000 with the defaults.
- Command-to-drive latency: 1 to FRAME_TICKS cycles, measured to the first frame boundary at or after acceptance.
- FWD to REV takes BRAKE_FRAMES + NEUTRAL_FRAMES + 1 boundaries while back is held.
- Simultaneous events:
  - A command and frame_start in the same cycle: the command is used via the bypass.
  - A command and watchdog expiry in the same cycle: the command wins.
- Back-to-back accepted commands within one frame: the last one wins.

## Structure
- Shared package car_pkg holds:
  - Drive code constants DRV_DRIVE = 2'b10, DRV_STOP = 2'b00, DRV_BACK = 2'b01. The PWM generator also uses these.
  - The state enum {ARM, IDLE, FWD, BRAKE, NEUTRAL, REV}.
- One sub-module, frame_timer, contains fcnt and generates frame_start, parameterised by FRAME_TICKS.
- The FSM, watchdog and tgt register stay in drive_sequencer.

## Test plan
- Reset, with commands driven from cycle 0:
  - cmd_ready = 0 and drive = 00 through cycle 1999.
  - armed = 1 at cycle 2000.
  - cmd drive accepted at cycle 2005 gives drive = 10 at cycle 2040.
- Hold back from FWD (defaults): drive sequence is 01 for 4 frames, then 00 for 5 frames, then 01 steady.
- In BRAKE after 2 frames, command drive: drive = 10 from the next boundary; NEUTRAL is never entered.
- In FWD, send no command for 25 boundaries:
  - failsafe = 1, and drive = 00 from the next frame.
  - A new cmd drive accepted at the next frame_start clears failsafe, and drive returns to 10 on that boundary.
- Command accepted in a frame_start cycle is applied at that boundary. A cmd = 11 from FWD yields 00.
- Assert rst for one cycle while in REV: next cycle drive = 00, armed = 0, state = ARM; re-arm takes 2000 cycles.

Source files
------------

// File: rtl/car_pkg.sv
// Shared drive-channel definitions: drive codes seen by the PWM generator and
// the sequencer state encoding.
package car_pkg;

    localparam logic [1:0] DRV_DRIVE = 2'b10;
    localparam logic [1:0] DRV_STOP  = 2'b00;
    localparam logic [1:0] DRV_BACK  = 2'b01;

    typedef enum logic [2:0] {ARM, IDLE, FWD, BRAKE, NEUTRAL, REV} seq_state_t;

    function automatic logic [1:0] drive_of(seq_state_t s);
        case (s)
            FWD:        return DRV_DRIVE;
            BRAKE, REV: return DRV_BACK;
            default:    return DRV_STOP;
        endcase
    endfunction

    // The reserved code 11 is folded into stop before anything downstream sees it.
    function automatic logic [1:0] sanitize(logic [1:0] c);
        return (c == 2'b11) ? DRV_STOP : c;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// PWM frame counter: fcnt runs 1..FRAME_TICKS, frame_start marks the last tick.
module frame_timer #(
    parameter int unsigned FRAME_TICKS = 40
) (
    input  logic clk_dec,
    input  logic rst,
    output logic frame_start
);

    localparam int unsigned CW = $clog2(FRAME_TICKS + 1);

    logic [CW-1:0] fcnt_q;

    assign frame_start = (fcnt_q == CW'(FRAME_TICKS));

    // Resetting to 1 keeps this counter aligned with the PWM generator's.
    always_ff @(posedge clk_dec) begin
        if (rst) begin
            fcnt_q <= CW'(1);
        end else if (frame_start) begin
            fcnt_q <= CW'(1);
        end else begin
            fcnt_q <= fcnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// ESC drive-channel sequencer: arming hold, brake-then-neutral reversal and
// command-timeout failsafe, with the drive code updated only at frame boundaries.
module drive_sequencer
    import car_pkg::*;
#(
    parameter int unsigned FRAME_TICKS    = 40,
    parameter int unsigned ARM_FRAMES     = 50,
    parameter int unsigned BRAKE_FRAMES   = 4,
    parameter int unsigned NEUTRAL_FRAMES = 5,
    parameter int unsigned TIMEOUT_FRAMES = 25
) (
    input  logic       clk_dec,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic [1:0] drive,
    output logic       armed,
    output logic       failsafe,
    output logic       frame_start
);

    localparam int unsigned PW = 16;
    localparam int unsigned WW = $clog2(TIMEOUT_FRAMES + 1);

    seq_state_t    state_q, state_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [1:0]    eff;
    logic [1:0]    drive_q;
    logic [WW-1:0] wd_q, wd_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          failsafe_q, failsafe_d;
    logic          accept;
    logic          expire;

    frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_frame_timer (
        .clk_dec     (clk_dec),
        .rst         (rst),
        .frame_start (frame_start)
    );

    assign armed     = (state_q != ARM);
    assign cmd_ready = armed;
    assign accept    = cmd_valid && cmd_ready;
    assign drive     = drive_q;
    assign failsafe  = failsafe_q;

    always_comb begin
        wd_d       = wd_q;
        failsafe_d = failsafe_q;
        expire     = 1'b0;
        if (accept) begin
            wd_d       = '0;
            failsafe_d = 1'b0;
        end else if (frame_start && armed) begin
            if (wd_q != WW'(TIMEOUT_FRAMES)) begin
                wd_d = wd_q + WW'(1);
            end
            if (wd_q == WW'(TIMEOUT_FRAMES - 1)) begin
                expire     = 1'b1;
                failsafe_d = 1'b1;
            end
        end
    end

    // An expiring watchdog already forces stop at its own boundary.
    always_comb begin
        tgt_d = accept ? sanitize(cmd) : tgt_q;
        if (accept) begin
            eff = sanitize(cmd);
        end else if (failsafe_q || expire) begin
            eff = DRV_STOP;
        end else begin
            eff = tgt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (phase_q != '1) begin
                phase_d = phase_q + PW'(1);
            end
            case (state_q)
                ARM: begin
                    if (phase_q >= PW'(ARM_FRAMES - 1)) state_d = IDLE;
                end
                IDLE: begin
                    if (eff == DRV_DRIVE)     state_d = FWD;
                    else if (eff == DRV_BACK) state_d = REV;
                end
                FWD: begin
                    if (eff == DRV_STOP)      state_d = IDLE;
                    else if (eff == DRV_BACK) state_d = BRAKE;
                end
                BRAKE: begin
                    if (eff == DRV_DRIVE)                        state_d = FWD;
                    else if (eff == DRV_STOP)                    state_d = IDLE;
                    else if (phase_q >= PW'(BRAKE_FRAMES - 1))   state_d = NEUTRAL;
                end
                NEUTRAL: begin
                    if (eff == DRV_DRIVE)                        state_d = FWD;
                    else if (eff == DRV_STOP)                    state_d = IDLE;
                    else if (phase_q >= PW'(NEUTRAL_FRAMES - 1)) state_d = REV;
                end
                REV: begin
                    if (eff == DRV_STOP)       state_d = IDLE;
                    else if (eff == DRV_DRIVE) state_d = FWD;
                end
                default: state_d = ARM;
            endcase
            if (state_d != state_q) begin
                phase_d = '0;
            end
        end
    end

    // drive follows the next state, so it can only move on a frame boundary.
    always_ff @(posedge clk_dec) begin
        if (rst) begin
            state_q    <= ARM;
            tgt_q      <= DRV_STOP;
            wd_q       <= '0;
            phase_q    <= '0;
            failsafe_q <= 1'b0;
            drive_q    <= DRV_STOP;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            wd_q       <= wd_d;
            phase_q    <= phase_d;
            failsafe_q <= failsafe_d;
            drive_q    <= drive_of(state_d);
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: expectations are queued per cycle and a
// monitor compares them against the outputs on the falling edge.
module tb_drive_sequencer;
    import car_pkg::*;

    localparam int FT = 40;

    logic       clk_dec   = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd       = 2'b00;
    logic       cmd_ready;
    logic [1:0] drive;
    logic       armed;
    logic       failsafe;
    logic       frame_start;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         c;
        logic [1:0] drv;
        logic       arm;
        logic       fs;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk_dec = ~clk_dec;

    drive_sequencer dut (
        .clk_dec     (clk_dec),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .drive       (drive),
        .armed       (armed),
        .failsafe    (failsafe),
        .frame_start (frame_start)
    );

    // cyc = 0 is the cycle right after the last reset edge.
    always @(posedge clk_dec) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, req);
        end
    endtask

    task automatic expect_at(int c, string name, logic [1:0] d, logic a, logic f);
        exp_t e;
        e.c    = c;
        e.drv  = d;
        e.arm  = a;
        e.fs   = f;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk_dec) begin : monitor
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].c < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.c, cyc);
            end
            if (sb.size() > 0 && sb[0].c == cyc) begin
                e = sb.pop_front();
                check({e.name, "/drive"},       int'(drive),       int'(e.drv));
                check({e.name, "/armed"},       int'(armed),       int'(e.arm));
                check({e.name, "/cmd_ready"},   int'(cmd_ready),   int'(e.arm));
                check({e.name, "/failsafe"},    int'(failsafe),    int'(e.fs));
                check({e.name, "/frame_start"}, int'(frame_start), int'((cyc % FT) == FT - 1));
            end
        end
    end

    task automatic at_cyc(int c);
        while (cyc < c) @(negedge clk_dec);
    endtask

    task automatic send(int c, logic [1:0] v);
        at_cyc(c);
        cmd_valid = 1'b1;
        cmd       = v;
        @(negedge clk_dec);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached at cyc %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk_dec);
        #1;
        // Arming hold with drive commands presented from cycle 0.
        expect_at(0,    "rst",       DRV_STOP,  1'b0, 1'b0);
        expect_at(1,    "pre_arm",   DRV_STOP,  1'b0, 1'b0);
        expect_at(1000, "pre_arm_m", DRV_STOP,  1'b0, 1'b0);
        expect_at(1999, "arm_edge",  DRV_STOP,  1'b0, 1'b0);
        expect_at(2000, "armed",     DRV_STOP,  1'b1, 1'b0);
        expect_at(2039, "idle",      DRV_STOP,  1'b1, 1'b0);
        expect_at(2040, "fwd",       DRV_DRIVE, 1'b1, 1'b0);
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd       = DRV_DRIVE;
        at_cyc(2000);
        cmd_valid = 1'b0;
        send(2005, DRV_DRIVE);

        // Back held from FWD: 4 frames brake, 5 frames neutral, then reverse.
        expect_at(2079, "fwd_hold",    DRV_DRIVE, 1'b1, 1'b0);
        expect_at(2080, "brake",       DRV_BACK,  1'b1, 1'b0);
        expect_at(2239, "brake_end",   DRV_BACK,  1'b1, 1'b0);
        expect_at(2240, "neutral",     DRV_STOP,  1'b1, 1'b0);
        expect_at(2439, "neutral_end", DRV_STOP,  1'b1, 1'b0);
        expect_at(2440, "rev",         DRV_BACK,  1'b1, 1'b0);
        expect_at(2470, "rev_steady",  DRV_BACK,  1'b1, 1'b0);
        send(2045, DRV_BACK);

        // Brake aborted by drive after two frames.
        expect_at(2480, "rev2fwd",     DRV_DRIVE, 1'b1, 1'b0);
        expect_at(2520, "brake2",      DRV_BACK,  1'b1, 1'b0);
        expect_at(2639, "brake2_hold", DRV_BACK,  1'b1, 1'b0);
        expect_at(2640, "brake_abort", DRV_DRIVE, 1'b1, 1'b0);
        expect_at(2720, "no_neutral",  DRV_DRIVE, 1'b1, 1'b0);
        send(2445, DRV_DRIVE);
        send(2485, DRV_BACK);
        send(2605, DRV_DRIVE);

        // Silence for 25 boundaries, then recovery by a command on frame_start.
        expect_at(3598, "pre_timeout",  DRV_DRIVE, 1'b1, 1'b0);
        expect_at(3599, "timeout_edge", DRV_DRIVE, 1'b1, 1'b0);
        expect_at(3600, "failsafe",     DRV_STOP,  1'b1, 1'b1);
        expect_at(3639, "fs_hold",      DRV_STOP,  1'b1, 1'b1);
        expect_at(3640, "fs_clear",     DRV_DRIVE, 1'b1, 1'b0);
        send(3639, DRV_DRIVE);

        // Reserved code on a boundary, back-to-back commands, stop, back from idle.
        expect_at(3679, "fwd_pre11", DRV_DRIVE, 1'b1, 1'b0);
        expect_at(3680, "rsv_stop",  DRV_STOP,  1'b1, 1'b0);
        expect_at(3720, "last_wins", DRV_DRIVE, 1'b1, 1'b0);
        expect_at(3760, "stop",      DRV_STOP,  1'b1, 1'b0);
        expect_at(3800, "idle2rev",  DRV_BACK,  1'b1, 1'b0);
        send(3679, 2'b11);
        send(3685, DRV_BACK);
        send(3686, DRV_DRIVE);
        send(3725, DRV_STOP);
        send(3765, DRV_BACK);

        // One-cycle reset while reversing; full re-arm follows.
        at_cyc(3810);
        rst = 1'b1;
        @(posedge clk_dec);
        #1;
        expect_at(0,    "mid_rst",    DRV_STOP,  1'b0, 1'b0);
        expect_at(1,    "rst_hold",   DRV_STOP,  1'b0, 1'b0);
        expect_at(1999, "rearm_edge", DRV_STOP,  1'b0, 1'b0);
        expect_at(2000, "rearmed",    DRV_STOP,  1'b1, 1'b0);
        expect_at(2040, "rearm_fwd",  DRV_DRIVE, 1'b1, 1'b0);
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd       = DRV_DRIVE;
        at_cyc(2050);
        cmd_valid = 1'b0;

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
